// File: rtl/kb_pkg.sv
// +----------------------------------------------------------------------------+
// | kb_pkg                                                                     |
// | Scan-code constants and decoder state encoding for the PS/2 keyboard path. |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

package kb_pkg;

    localparam logic [7:0] c_BREAK   = 8'hF0;
    localparam logic [7:0] c_EXT     = 8'hE0;
    localparam logic [7:0] c_L_SHIFT = 8'h12;
    localparam logic [7:0] c_R_SHIFT = 8'h59;

    localparam int         c_ST_W       = 2;
    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_BRK     = 2'd1;
    localparam logic [1:0] c_ST_EXT     = 2'd2;
    localparam logic [1:0] c_ST_EXT_BRK = 2'd3;

    function automatic logic is_shift_code(input logic [7:0] code);
        return (code == c_L_SHIFT) || (code == c_R_SHIFT);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_frame_rx.sv
// +----------------------------------------------------------------------------+
// | ps2_frame_rx                                                               |
// | Synchronises and filters PS/2 clock/data and frames 11-bit packets.        |
// | Macro KB_PARITY_CHECK_EN adds odd-parity checking to frame_bad.            |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module ps2_frame_rx #(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int FILTER_LEN     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2c,
    input  logic       ps2d,
    output logic [7:0] code,
    output logic       frame_done,
    output logic       frame_bad
);

    localparam int c_FW = $clog2(FILTER_LEN + 1);
    localparam int c_TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_FW-1:0] c_FLT_LAST = c_FW'(FILTER_LEN - 1);
    localparam logic [c_TW-1:0] c_TO_LAST  = c_TW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]      c_LAST_BIT = 4'd10;

    logic            r_c_s1, r_c_s2, r_d_s1, r_d_s2;
    logic            r_c_flt;
    logic [c_FW-1:0] r_flt_cnt;
    logic [3:0]      r_bit_cnt;
    logic [9:0]      r_shift;
    logic [c_TW-1:0] r_to_cnt;
    logic [7:0]      r_code;
    logic            r_done, r_bad;

    logic w_flt_chg, w_edge, w_fall, w_last, w_timeout, w_bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_c_s1 <= 1'b1;
            r_c_s2 <= 1'b1;
            r_d_s1 <= 1'b1;
            r_d_s2 <= 1'b1;
        end else begin
            r_c_s1 <= ps2c;
            r_c_s2 <= r_c_s1;
            r_d_s1 <= ps2d;
            r_d_s2 <= r_d_s1;
        end
    end

    // A level change is accepted only after FILTER_LEN consecutive differing samples
    assign w_flt_chg = (r_c_s2 != r_c_flt);
    assign w_edge    = w_flt_chg && (r_flt_cnt == c_FLT_LAST);
    assign w_fall    = w_edge && r_c_flt;
    assign w_last    = (r_bit_cnt == c_LAST_BIT);
    assign w_timeout = (r_bit_cnt != 4'd0) && (r_to_cnt == c_TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_c_flt   <= 1'b1;
            r_flt_cnt <= '0;
        end else if (!w_flt_chg || w_edge) begin
            r_flt_cnt <= '0;
            if (w_edge) r_c_flt <= r_c_s2;
        end else begin
            r_flt_cnt <= r_flt_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
        end else if (w_edge || (r_bit_cnt == 4'd0) || w_timeout) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    always_comb begin
        w_bad = r_shift[0] | ~r_d_s2;
`ifdef KB_PARITY_CHECK_EN
        w_bad = w_bad | ~(^r_shift[9:1]);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt <= 4'd0;
            r_shift   <= '0;
            r_code    <= 8'h00;
            r_done    <= 1'b0;
            r_bad     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_bad  <= 1'b0;
            if (w_fall) begin
                if (w_last) begin
                    r_bit_cnt <= 4'd0;
                    r_code    <= r_shift[8:1];
                    r_done    <= 1'b1;
                    r_bad     <= w_bad;
                end else begin
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                    r_shift   <= {r_d_s2, r_shift[9:1]};
                end
            end else if (w_timeout) begin
                r_bit_cnt <= 4'd0;
            end
        end
    end

    assign code       = r_code;
    assign frame_done = r_done;
    assign frame_bad  = r_bad;

endmodule

`default_nettype wire

// File: rtl/scan_to_ascii.sv
// +----------------------------------------------------------------------------+
// | scan_to_ascii                                                              |
// | Set-2 make code to ASCII; letter_case selects upper-case letters.          |
// | Unmapped codes return 0x00.                                                |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module scan_to_ascii (
    input  logic [7:0] scan_code,
    input  logic       letter_case,
    output logic [7:0] ascii_code
);

    logic [7:0] w_base;
    logic       w_is_letter;

    always_comb begin
        w_base      = 8'h00;
        w_is_letter = 1'b1;
        case (scan_code)
            8'h1C: w_base = 8'h61; 8'h32: w_base = 8'h62; 8'h21: w_base = 8'h63;
            8'h23: w_base = 8'h64; 8'h24: w_base = 8'h65; 8'h2B: w_base = 8'h66;
            8'h34: w_base = 8'h67; 8'h33: w_base = 8'h68; 8'h43: w_base = 8'h69;
            8'h3B: w_base = 8'h6A; 8'h42: w_base = 8'h6B; 8'h4B: w_base = 8'h6C;
            8'h3A: w_base = 8'h6D; 8'h31: w_base = 8'h6E; 8'h44: w_base = 8'h6F;
            8'h4D: w_base = 8'h70; 8'h15: w_base = 8'h71; 8'h2D: w_base = 8'h72;
            8'h1B: w_base = 8'h73; 8'h2C: w_base = 8'h74; 8'h3C: w_base = 8'h75;
            8'h2A: w_base = 8'h76; 8'h1D: w_base = 8'h77; 8'h22: w_base = 8'h78;
            8'h35: w_base = 8'h79; 8'h1A: w_base = 8'h7A;
            default: begin
                w_is_letter = 1'b0;
                case (scan_code)
                    8'h45: w_base = 8'h30; 8'h16: w_base = 8'h31; 8'h1E: w_base = 8'h32;
                    8'h26: w_base = 8'h33; 8'h25: w_base = 8'h34; 8'h2E: w_base = 8'h35;
                    8'h36: w_base = 8'h36; 8'h3D: w_base = 8'h37; 8'h3E: w_base = 8'h38;
                    8'h46: w_base = 8'h39;
                    8'h29: w_base = 8'h20;
                    8'h5A: w_base = 8'h0D;
                    8'h66: w_base = 8'h08;
                    default: w_base = 8'h00;
                endcase
            end
        endcase
    end

    // Upper case is the lower-case code minus 0x20; only letters are affected
    assign ascii_code = (w_is_letter && letter_case) ? (w_base - 8'h20) : w_base;

endmodule

`default_nettype wire

// File: rtl/ps2_kb_ctrl.sv
// +----------------------------------------------------------------------------+
// | ps2_kb_ctrl                                                                |
// | PS/2 keyboard controller: framing, make/break/shift decode, ASCII FIFO.    |
// | Macro KB_PARITY_CHECK_EN enables parity checking in the frame receiver.    |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module ps2_kb_ctrl
    import kb_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int FILTER_LEN     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2c,
    input  logic       ps2d,
    output logic [7:0] key,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       shift_active,
    output logic       overflow,
    output logic       frame_err
);

    localparam int c_AW = $clog2(FIFO_DEPTH);

    logic [7:0]      w_rx_code;
    logic            w_rx_done, w_rx_bad;
    logic [7:0]      r_code;
    logic            r_dec_en, r_frame_err;
    logic [c_ST_W-1:0] r_state, w_state_nxt;
    logic            r_lshift, r_rshift, w_lshift_nxt, w_rshift_nxt;
    logic [7:0]      w_ascii;
    logic            w_emit;

    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [c_AW:0]   r_wr_ptr, r_rd_ptr;
    logic            r_overflow;
    logic            w_empty, w_full, w_pop, w_push;

    ps2_frame_rx #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .FILTER_LEN     (FILTER_LEN)
    ) u_frame_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .ps2c       (ps2c),
        .ps2d       (ps2d),
        .code       (w_rx_code),
        .frame_done (w_rx_done),
        .frame_bad  (w_rx_bad)
    );

    // One-cycle pipeline stage: the decoder acts on the cycle after frame_done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_code      <= 8'h00;
            r_dec_en    <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_dec_en    <= w_rx_done && !w_rx_bad;
            r_frame_err <= w_rx_done && w_rx_bad;
            if (w_rx_done) r_code <= w_rx_code;
        end
    end

    scan_to_ascii u_scan_to_ascii (
        .scan_code   (r_code),
        .letter_case (shift_active),
        .ascii_code  (w_ascii)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_ST_IDLE;
            r_lshift <= 1'b0;
            r_rshift <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_lshift <= w_lshift_nxt;
            r_rshift <= w_rshift_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_lshift_nxt = r_lshift;
        w_rshift_nxt = r_rshift;
        w_emit       = 1'b0;
        if (r_dec_en) begin
            case (r_state)
                c_ST_IDLE: begin
                    if (r_code == c_BREAK)        w_state_nxt  = c_ST_BRK;
                    else if (r_code == c_EXT)     w_state_nxt  = c_ST_EXT;
                    else if (r_code == c_L_SHIFT) w_lshift_nxt = 1'b1;
                    else if (r_code == c_R_SHIFT) w_rshift_nxt = 1'b1;
                    else                          w_emit       = (w_ascii != 8'h00);
                end
                c_ST_BRK: begin
                    if (r_code == c_L_SHIFT) w_lshift_nxt = 1'b0;
                    if (r_code == c_R_SHIFT) w_rshift_nxt = 1'b0;
                    w_state_nxt = c_ST_IDLE;
                end
                c_ST_EXT: begin
                    w_state_nxt = (r_code == c_BREAK) ? c_ST_EXT_BRK : c_ST_IDLE;
                end
                default: begin
                    w_state_nxt = c_ST_IDLE;
                end
            endcase
        end
    end

    assign shift_active = r_lshift | r_rshift;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_pop   = !w_empty && key_ready;
    // When full, a simultaneous pop frees the head slot that the push then reuses
    assign w_push  = w_emit && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[c_AW-1:0]] <= w_ascii;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= w_emit && !w_push;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    assign key_valid = !w_empty;
    assign key       = w_empty ? 8'h00 : r_mem[r_rd_ptr[c_AW-1:0]];
    assign overflow  = r_overflow;
    assign frame_err = r_frame_err;

endmodule

`default_nettype wire

// File: tb/tb_ps2_kb_ctrl.sv
// +----------------------------------------------------------------------------+
// | tb_ps2_kb_ctrl                                                             |
// | Directed self-checking bench for ps2_kb_ctrl.                              |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_ps2_kb_ctrl;

    localparam int c_HP = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2c = 1'b1;
    logic       ps2d = 1'b1;
    logic       key_ready = 1'b1;
    logic [7:0] key;
    logic       key_valid, shift_active, overflow, frame_err;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] key_q[$];
    int         n_ovf = 0;
    int         n_ferr = 0;

    ps2_kb_ctrl #(
        .FIFO_DEPTH     (8),
        .TIMEOUT_CYCLES (1000),
        .FILTER_LEN     (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ps2c         (ps2c),
        .ps2d         (ps2d),
        .key          (key),
        .key_valid    (key_valid),
        .key_ready    (key_ready),
        .shift_active (shift_active),
        .overflow     (overflow),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            if (key_valid && key_ready) key_q.push_back(key);
            if (overflow)  n_ovf++;
            if (frame_err) n_ferr++;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [10:0] frame, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            ps2d = frame[i];
            wait_clks(c_HP);
            ps2c = 1'b0;
            wait_clks(c_HP);
            ps2c = 1'b1;
        end
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] code, input logic bad_par,
                                             input logic bad_stop);
        logic par;
        par = ~(^code) ^ bad_par;
        return {~bad_stop, par, code, 1'b0};
    endfunction

    task automatic send_code(input logic [7:0] code);
        send_bits(mk_frame(code, 1'b0, 1'b0), 11);
        ps2d = 1'b1;
        wait_clks(60);
    endtask

    int base_k, base_o, base_f;

    task automatic mark();
        base_k = key_q.size();
        base_o = n_ovf;
        base_f = n_ferr;
    endtask

    initial begin
        wait_clks(3);
        check_val("rst_key",       32'(key), 32'h0);
        check_val("rst_key_valid", 32'(key_valid), 32'h0);
        check_val("rst_shift",     32'(shift_active), 32'h0);
        check_val("rst_overflow",  32'(overflow), 32'h0);
        check_val("rst_frame_err", 32'(frame_err), 32'h0);
        rst_n = 1'b1;
        wait_clks(10);

        // 1: plain make/break of 'a'
        mark();
        send_code(8'h1C);
        check_val("t1_shift", 32'(shift_active), 32'h0);
        send_code(8'hF0);
        send_code(8'h1C);
        check_val("t1_nkeys", 32'(key_q.size() - base_k), 32'd1);
        if (key_q.size() > base_k) check_val("t1_key", 32'(key_q[base_k]), 32'h61);
        check_val("t1_shift_end", 32'(shift_active), 32'h0);

        // 2: shifted 'A'
        mark();
        send_code(8'h12);
        check_val("t2_shift_on", 32'(shift_active), 32'h1);
        send_code(8'h1C);
        send_code(8'hF0);
        send_code(8'h1C);
        send_code(8'hF0);
        check_val("t2_shift_held", 32'(shift_active), 32'h1);
        send_code(8'h12);
        check_val("t2_shift_off", 32'(shift_active), 32'h0);
        check_val("t2_nkeys", 32'(key_q.size() - base_k), 32'd1);
        if (key_q.size() > base_k) check_val("t2_key", 32'(key_q[base_k]), 32'h41);

        // 3: fill FIFO past depth with consumer stalled
        key_ready = 1'b0;
        mark();
        for (int i = 0; i < 9; i++) begin
            send_code(8'h1C);
            send_code(8'hF0);
            send_code(8'h1C);
        end
        check_val("t3_ovf_pulses", 32'(n_ovf - base_o), 32'd1);
        check_val("t3_valid_full", 32'(key_valid), 32'h1);
        check_val("t3_key_stable", 32'(key), 32'h61);
        check_val("t3_no_pop", 32'(key_q.size() - base_k), 32'd0);
        key_ready = 1'b1;
        wait_clks(20);
        check_val("t3_drained", 32'(key_q.size() - base_k), 32'd8);
        for (int i = 0; i < 8; i++)
            if (key_q.size() > base_k + i) check_val("t3_drain_key", 32'(key_q[base_k + i]), 32'h61);
        check_val("t3_valid_low", 32'(key_valid), 32'h0);

        // 4: parity error on 'a', then stop-bit error
        mark();
        send_bits(mk_frame(8'h1C, 1'b1, 1'b0), 11);
        ps2d = 1'b1;
        wait_clks(60);
`ifdef KB_PARITY_CHECK_EN
        check_val("t4_par_ferr", 32'(n_ferr - base_f), 32'd1);
        check_val("t4_par_nkeys", 32'(key_q.size() - base_k), 32'd0);
`else
        check_val("t4_par_ferr", 32'(n_ferr - base_f), 32'd0);
        check_val("t4_par_nkeys", 32'(key_q.size() - base_k), 32'd1);
        if (key_q.size() > base_k) check_val("t4_par_key", 32'(key_q[base_k]), 32'h61);
`endif
        mark();
        send_bits(mk_frame(8'h32, 1'b0, 1'b1), 11);
        ps2d = 1'b1;
        wait_clks(60);
        check_val("t4_stop_ferr", 32'(n_ferr - base_f), 32'd1);
        check_val("t4_stop_nkeys", 32'(key_q.size() - base_k), 32'd0);

        // 5: partial frame abandoned by timeout
        mark();
        send_bits(mk_frame(8'h1C, 1'b0, 1'b0), 5);
        ps2d = 1'b1;
        wait_clks(1500);
        send_code(8'h32);
        check_val("t5_nkeys", 32'(key_q.size() - base_k), 32'd1);
        if (key_q.size() > base_k) check_val("t5_key", 32'(key_q[base_k]), 32'h62);
        check_val("t5_ferr", 32'(n_ferr - base_f), 32'd0);

        // 6: extended keys emit nothing
        mark();
        send_code(8'hE0);
        send_code(8'h75);
        send_code(8'hE0);
        send_code(8'hF0);
        send_code(8'h75);
        check_val("t6_nkeys", 32'(key_q.size() - base_k), 32'd0);
        check_val("t6_valid", 32'(key_valid), 32'h0);
        check_val("t6_shift", 32'(shift_active), 32'h0);

        // 6b: reset mid-frame with shift held and a character pending
        key_ready = 1'b0;
        send_code(8'h59);
        send_code(8'h1C);
        check_val("t6_pre_shift", 32'(shift_active), 32'h1);
        check_val("t6_pre_valid", 32'(key_valid), 32'h1);
        send_bits(mk_frame(8'h1C, 1'b0, 1'b0), 5);
        rst_n = 1'b0;
        wait_clks(2);
        check_val("t6_rst_key", 32'(key), 32'h0);
        check_val("t6_rst_valid", 32'(key_valid), 32'h0);
        check_val("t6_rst_shift", 32'(shift_active), 32'h0);
        check_val("t6_rst_ovf", 32'(overflow), 32'h0);
        check_val("t6_rst_ferr", 32'(frame_err), 32'h0);
        ps2d = 1'b1;
        wait_clks(5);
        rst_n = 1'b1;
        key_ready = 1'b1;
        wait_clks(5);
        mark();
        send_code(8'h1C);
        check_val("t6_post_nkeys", 32'(key_q.size() - base_k), 32'd1);
        if (key_q.size() > base_k) check_val("t6_post_key", 32'(key_q[base_k]), 32'h61);
        check_val("t6_post_ferr", 32'(n_ferr - base_f), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
